// File: rtl/serv_rf_dbg_port.sv
// ---------------------------------------------------------------------------
// serv_rf_dbg_port
//
// Debug-side initiator for the bit-serial SERV register-file interface.
// A parallel host command (read or write one GPR/CSR slot, 32-bit data) is
// turned into the same serial request/data sequence the SERV core drives into
// serv_rf_ram_if.  Serial read data is collected back into a 32-bit word.
// An external mux hands the RF request port to this block while the core is
// halted.
//
// Optional feature macro: SERV_RF_DBG_X0_GUARD_EN
//   When defined, a write to slot 0 runs the complete write sequence but
//   keeps o_wen0 low, so x0 is never modified.
//
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_cmd_valid/o_cmd_ready host command handshake
//   i_cmd_we                1 = write, 0 = read
//   i_cmd_reg, i_cmd_wdata  target slot and write data
//   o_rsp_valid             one-cycle completion pulse (reads and writes)
//   o_rsp_rdata             last read result, held until the next read ends
//   o_wreq, o_rreq          RF write / read request
//   i_ready                 RF grant (only looked at while waiting on a read)
//   o_wreg0, o_wen0         write slot and write enable, port 0
//   o_wdata0                serial write data, LSB first
//   o_rreg0                 read slot, port 0
//   i_rdata0                serial read data, LSB first
// ---------------------------------------------------------------------------
module serv_rf_dbg_port #(
    parameter int csr_regs = 4,
    parameter int raw      = $clog2(32 + csr_regs)
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_cmd_valid,
    output logic           o_cmd_ready,
    input  logic           i_cmd_we,
    input  logic [raw-1:0] i_cmd_reg,
    input  logic [31:0]    i_cmd_wdata,
    output logic           o_rsp_valid,
    output logic [31:0]    o_rsp_rdata,
    output logic           o_wreq,
    output logic           o_rreq,
    input  logic           i_ready,
    output logic [raw-1:0] o_wreg0,
    output logic           o_wen0,
    output logic           o_wdata0,
    output logic [raw-1:0] o_rreg0,
    input  logic           i_rdata0
);

    typedef enum logic [2:0] {
        IDLE,
        WREQ,
        WSHIFT,
        WFLUSH,
        RREQ,
        RWAIT,
        RSHIFT
    } state_e;

    state_e          state_q;
    logic [4:0]      cnt_q;
    logic            flush_q;      // second WFLUSH cycle marker
    logic [31:0]     shreg_q;
    logic [raw-1:0]  reg_q;
    logic            cmd_ready_q;
    logic            wreq_q;
    logic            rreq_q;
    logic            wen_q;
    logic            wdata_q;
    logic            rsp_valid_q;
    logic [31:0]     rdata_q;

    // Write enable granted to the accepted command.
    logic wen_allow_d;
`ifdef SERV_RF_DBG_X0_GUARD_EN
    assign wen_allow_d = (i_cmd_reg != '0);
`else
    assign wen_allow_d = 1'b1;
`endif

    // Serial read word including the bit arriving this cycle.
    logic [31:0] rshift_d;
    assign rshift_d = {i_rdata0, shreg_q[31:1]};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            flush_q     <= 1'b0;
            shreg_q     <= '0;
            reg_q       <= '0;
            cmd_ready_q <= 1'b1;
            wreq_q      <= 1'b0;
            rreq_q      <= 1'b0;
            wen_q       <= 1'b0;
            wdata_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            // Single-cycle pulses default low.
            wreq_q      <= 1'b0;
            rreq_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        shreg_q     <= i_cmd_wdata;
                        reg_q       <= i_cmd_reg;
                        cnt_q       <= '0;
                        if (i_cmd_we) begin
                            state_q <= WREQ;
                            wreq_q  <= 1'b1;
                            wen_q   <= wen_allow_d;
                        end else begin
                            state_q <= RREQ;
                            rreq_q  <= 1'b1;
                        end
                    end
                end
                WREQ: begin
                    // Preload bit 0 so it is on the wire in the first WSHIFT cycle.
                    state_q <= WSHIFT;
                    cnt_q   <= '0;
                    wdata_q <= shreg_q[0];
                    shreg_q <= shreg_q >> 1;
                end
                WSHIFT: begin
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q <= WFLUSH;
                        wdata_q <= 1'b0;
                        flush_q <= 1'b0;
                    end else begin
                        wdata_q <= shreg_q[0];
                        shreg_q <= shreg_q >> 1;
                    end
                end
                WFLUSH: begin
                    if (!flush_q) begin
                        flush_q     <= 1'b1;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        flush_q     <= 1'b0;
                        state_q     <= IDLE;
                        cmd_ready_q <= 1'b1;
                        wen_q       <= 1'b0;
                        reg_q       <= '0;
                    end
                end
                RREQ: begin
                    state_q <= RWAIT;
                end
                RWAIT: begin
                    if (i_ready) begin
                        state_q <= RSHIFT;
                        cnt_q   <= '0;
                    end
                end
                RSHIFT: begin
                    shreg_q <= rshift_d;
                    cnt_q   <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        rdata_q     <= rshift_d;
                        rsp_valid_q <= 1'b1;
                        state_q     <= IDLE;
                        cmd_ready_q <= 1'b1;
                        reg_q       <= '0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b1;
                    wen_q       <= 1'b0;
                    reg_q       <= '0;
                end
            endcase
        end
    end

    assign o_cmd_ready = cmd_ready_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_rdata = rdata_q;
    assign o_wreq      = wreq_q;
    assign o_rreq      = rreq_q;
    assign o_wreg0     = reg_q;
    assign o_rreg0     = reg_q;
    assign o_wen0      = wen_q;
    assign o_wdata0    = wdata_q;

endmodule
